// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module  : count_pkg
// Purpose : Default generics and direction encodings for the LED up/down count.
// Revision: 1.0
// ============================================================================
package count_pkg;

  localparam int DEFAULT_WIDTH        = 4;
  localparam int DEFAULT_PRESCALE_W   = 25;
  localparam int DEFAULT_PRESCALE_MAX = (2 ** 25) - 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : count_pkg
`default_nettype wire

// File: rtl/count_updown_prescaled_if.sv
`default_nettype none
// ============================================================================
// Module  : count_updown_prescaled_if
// Purpose : LED-count partition interface; master drives controls, slave is RM.
// Revision: 1.0
// ============================================================================
interface count_updown_prescaled_if
  import count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             dir;
  logic             wrap_en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_out;
  logic             tick;
  logic             tc;

  modport master (
    output en, dir, wrap_en, load, load_val,
    input  count_out, tick, tc
  );

  modport slave (
    input  en, dir, wrap_en, load, load_val,
    output count_out, tick, tc
  );

endinterface : count_updown_prescaled_if
`default_nettype wire

// File: rtl/count_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : count_prescaler
// Purpose : Free-running enable-gated divider; step pulses on the terminal phase.
// Revision: 1.0
// ============================================================================
module count_prescaler
  import count_pkg::*;
#(
  parameter int PRESCALE_W   = DEFAULT_PRESCALE_W,
  parameter int PRESCALE_MAX = DEFAULT_PRESCALE_MAX
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en,
  input  wire logic clr,
  output logic      step
);

  localparam logic [PRESCALE_W-1:0] c_max = PRESCALE_W'(PRESCALE_MAX);
  localparam logic [PRESCALE_W-1:0] c_one = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_phase;
  logic                  w_at_max;

  assign w_at_max = (r_phase == c_max);
  assign step     = en & w_at_max;

  // Disabled cycles leave the phase untouched so re-enabling adds no extra step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (clr) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= w_at_max ? '0 : (r_phase + c_one);
    end
  end

endmodule : count_prescaler
`default_nettype wire

// File: rtl/count_updown_prescaled.sv
`default_nettype none
// ============================================================================
// Module  : count_updown_prescaled
// Purpose : Prescaled up/down LED counter with wrap/saturate, load and tc flag.
// Revision: 1.0
// ============================================================================
module count_updown_prescaled
  import count_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter int               PRESCALE_W   = DEFAULT_PRESCALE_W,
  parameter int               PRESCALE_MAX = DEFAULT_PRESCALE_MAX,
  parameter logic [WIDTH-1:0] RESET_VAL    = '1
) (
  input wire logic                clk,
  input wire logic                rst_n,
  count_updown_prescaled_if.slave bus
);

  localparam logic [WIDTH-1:0] c_max = '1;
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic             w_step;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_stepped;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_tc;

  count_prescaler #(
    .PRESCALE_W   (PRESCALE_W),
    .PRESCALE_MAX (PRESCALE_MAX)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .step  (w_step)
  );

  // Modulo arithmetic gives the wrap result for free; saturation just holds.
  always_comb begin
    w_at_bound = 1'b0;
    w_stepped  = r_count;
    if (bus.dir == DIR_UP) begin
      w_at_bound = (r_count == c_max);
      w_stepped  = r_count + c_one;
    end else begin
      w_at_bound = (r_count == '0);
      w_stepped  = r_count - c_one;
    end
    w_next = (w_at_bound && !bus.wrap_en) ? r_count : w_stepped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RESET_VAL;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (bus.load) begin
      r_count <= bus.load_val;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_tick  <= 1'b1;
      r_tc    <= w_at_bound;
    end else begin
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end
  end

  assign bus.count_out = r_count;
  assign bus.tick      = r_tick;
  assign bus.tc        = r_tc;

endmodule : count_updown_prescaled
`default_nettype wire
